// File: rtl/instr_arbiter.sv
// Round-robin arbiter sharing one in-order execution core among N_REQ requesters.
// An in-order tag FIFO remembers who issued each instruction so results route back to the issuer.
module instr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                           i_CLK,
  input  logic                           i_RSTn,
  input  logic [32*N_REQ-1:0]            i_req_instr,
  input  logic [N_REQ-1:0]               i_req_valid,
  output logic [N_REQ-1:0]               o_req_ready,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic [N_REQ-1:0]               o_rsp_valid,
  output logic [31:0]                    o_core_instr,
  output logic                           o_core_valid,
  input  logic                           i_core_ready,
  input  logic [DATA_WIDTH-1:0]          i_core_data,
  input  logic                           i_core_valid,
  output logic [$clog2(TAG_DEPTH+1)-1:0] o_outstanding,
  output logic                           o_err_orphan
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH+1);

  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]      tag_q [TAG_DEPTH];
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic                  err_orphan_q;

  logic                  gnt_any_s;
  logic [IDX_W-1:0]      gnt_idx_s;
  logic [IDX_W-1:0]      cand_s;
  logic                  full_s;
  logic                  fire_s;
  logic                  pop_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Round-robin search: first valid requester at or after the rr pointer, with wrap
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = IDX_W'((int'(rr_q) + i) % N_REQ);
      if (!gnt_any_s && i_req_valid[cand_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Core-side handshake; full comes only from the registered count, never from i_core_valid
  always_comb begin
    full_s       = (count_q == CNT_W'(TAG_DEPTH));
    o_core_valid = gnt_any_s & ~full_s;
    fire_s       = o_core_valid & i_core_ready;
    pop_s        = i_core_valid & (count_q != '0);
    o_req_ready  = '0;
    if (gnt_any_s) begin
      o_core_instr = i_req_instr[32*gnt_idx_s +: 32];
      o_req_ready[gnt_idx_s] = i_core_ready & ~full_s;
    end else begin
      o_core_instr = 32'd0;
    end
  end

  // Next-state for the rr pointer and the outstanding count
  always_comb begin
    if (fire_s) begin
      rr_d = (gnt_idx_s == IDX_W'(N_REQ-1)) ? '0 : gnt_idx_s + 1'b1;
    end else begin
      rr_d = rr_q;
    end
    case ({fire_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State, tag FIFO and registered response/error outputs
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      rr_q         <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      err_orphan_q <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (fire_s) begin
        tag_q[wptr_q] <= gnt_idx_s;
        wptr_q        <= wptr_q + 1'b1;
      end else begin
        wptr_q <= wptr_q;
      end
      if (pop_s) begin
        rsp_data_q  <= i_core_data;
        rsp_valid_q <= onehot(tag_q[rptr_q]);
        rptr_q      <= rptr_q + 1'b1;
      end else begin
        rsp_valid_q <= '0;
      end
      // A result with nothing outstanding is dropped and flagged until reset
      if (i_core_valid && (count_q == '0)) begin
        err_orphan_q <= 1'b1;
      end else begin
        err_orphan_q <= err_orphan_q;
      end
    end
  end

  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_outstanding = count_q;
  assign o_err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_instr_arbiter.sv
// Directed bench for instr_arbiter: inputs change 1ns after the rising edge, outputs sampled 2ns after.
module tb_instr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TD = 4;

  logic            clk;
  logic            rst_n;
  logic [32*N-1:0] req_instr;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     core_instr;
  logic            core_valid;
  logic            core_ready;
  logic [DW-1:0]   core_data;
  logic            core_rvalid;
  logic [2:0]      outstanding;
  logic            err_orphan;

  int checks = 0;
  int errors = 0;

  instr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_req_instr(req_instr), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid),
    .o_core_instr(core_instr), .o_core_valid(core_valid), .i_core_ready(core_ready),
    .i_core_data(core_data), .i_core_valid(core_rvalid),
    .o_outstanding(outstanding), .o_err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_instr   = '0;
    req_valid   = '0;
    core_ready  = 1'b0;
    core_data   = '0;
    core_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b expected 0", err_orphan); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_core_valid: got %b expected 0", core_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_instr[64 +: 32] = 32'h00A1_2345;
    req_valid  = 4'b0100;
    core_ready = 1'b1;
    #1;
    checks++; if (core_instr !== 32'h00A1_2345) begin errors++; $display("FAIL single_instr: got %h expected 00a12345", core_instr); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL single_core_valid: got %b expected 1", core_valid); end
    tick();
    req_valid   = 4'b0000;
    core_rvalid = 1'b1;
    core_data   = 8'h5C;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding); end
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_data !== 8'h5C) begin errors++; $display("FAIL single_rsp_data: got %h expected 5c", rsp_data); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_outstanding0: got %0d expected 0", outstanding); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < N; k++) req_instr[32*k +: 32] = 32'h1000_0000 + k;
    core_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid   = (c < 8) ? 4'b1111 : 4'b0000;
      core_rvalid = (c >= 2 && c < 10);
      core_data   = 8'(8'h40 + c - 2);
      #1;
      if (c < 8) begin
        exp_oh = 4'b0001 << (c % 4);
        checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_oh); end
        checks++; if (core_instr !== 32'h1000_0000 + (c % 4)) begin errors++; $display("FAIL rr_instr c=%0d: got %h expected %h", c, core_instr, 32'h1000_0000 + (c % 4)); end
      end
      if (c >= 3 && c <= 10) begin
        exp_oh = 4'b0001 << ((c - 3) % 4);
        exp_d  = 8'(8'h40 + c - 3);
        checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, exp_oh); end
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL rr_rsp_data c=%0d: got %h expected %h", c, rsp_data, exp_d); end
      end
      tick();
    end
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rr_drained: got %0d expected 0", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    req_valid  = 4'b1111;
    core_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL full_core_valid: got %b expected 0", core_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_req_ready: got %b expected 0000", req_ready); end
    tick();
    core_rvalid = 1'b1;
    core_data   = 8'h99;
    #1;
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL full_pop_no_issue: got %b expected 0", core_valid); end
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL full_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 8'h99) begin errors++; $display("FAIL full_rsp_data: got %h expected 99", rsp_data); end
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_after_pop: got %0d expected 3", outstanding); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_resume: got %b expected 0001", req_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    core_ready = 1'b1;
    req_valid  = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_grant3: got %b expected 1000", req_ready); end
    tick();
    req_valid   = 4'b0001;
    core_rvalid = 1'b1;
    core_data   = 8'h11;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL b2b_count_before: got %0d expected 2", outstanding); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    core_data = 8'h22;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL b2b_count_same: got %0d expected 2", outstanding); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL b2b_rsp_old: got %b expected 0010", rsp_valid); end
    checks++; if (rsp_data !== 8'h11) begin errors++; $display("FAIL b2b_data_old: got %h expected 11", rsp_data); end
    tick();
    core_data = 8'h33;
    #1;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL b2b_rsp_mid: got %b expected 1000", rsp_valid); end
    checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL b2b_data_mid: got %h expected 22", rsp_data); end
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL b2b_rsp_new: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 8'h33) begin errors++; $display("FAIL b2b_data_new: got %h expected 33", rsp_data); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_count_end: got %0d expected 0", outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    core_rvalid = 1'b1;
    core_data   = 8'h77;
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %b expected 1", err_orphan); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL orphan_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL orphan_rsp_data: got %h expected 00", rsp_data); end
    tick();
    req_instr[0 +: 32] = 32'hDEAD_BEEF;
    req_valid  = 4'b0001;
    core_ready = 1'b1;
    #1;
    checks++; if (core_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL orphan_next_instr: got %h expected deadbeef", core_instr); end
    tick();
    req_valid   = 4'b0000;
    core_rvalid = 1'b1;
    core_data   = 8'h42;
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL orphan_next_rsp: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 8'h42) begin errors++; $display("FAIL orphan_next_data: got %h expected 42", rsp_data); end
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req_valid  = 4'b1111;
    core_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    req_valid   = 4'b0000;
    core_rvalid = 1'b1;
    core_data   = 8'h66;
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL rst_pre_count: got %0d expected 3", outstanding); end
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_pre_rsp: got %b expected 0001", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", outstanding); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_async_rsp: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h expected 00", rsp_data); end
    tick();
    rst_n       = 1'b1;
    core_rvalid = 1'b1;
    core_data   = 8'h55;
    tick();
    core_rvalid = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL rst_late_orphan: got %b expected 1", err_orphan); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_late_rsp: got %b expected 0000", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_back_to_back();
    test_orphan();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
